// File: rtl/cmp_pkg.sv
// Shared codes, FSM states and helpers for the comparator result monitor.
package cmp_pkg;

    localparam logic [2:0] LEG_L    = 3'b100;
    localparam logic [2:0] LEG_E    = 3'b010;
    localparam logic [2:0] LEG_G    = 3'b001;
    localparam logic [2:0] LEG_NONE = 3'b000;

    typedef enum logic [1:0] {IDLE, TRACK, ALARM} mon_state_t;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == LEG_L) || (v == LEG_E) || (v == LEG_G);
    endfunction

endpackage

// File: rtl/cmp_result_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and an optional load-to-1 (run restart).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         load1,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (load1)
            cnt_d = ONE;
        else if (inc && (cnt_q != MAX))
            cnt_d = cnt_q + ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;

endmodule

// File: rtl/cmp_result_monitor.sv
// Qualifies comparator l/e/g results, counts them, flags illegal codes and tracks
// the current run of identical results with a run-length alarm.
module cmp_result_monitor
    import cmp_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int RUN_W     = 4,
    parameter int ALARM_RUN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_l,
    input  logic             in_e,
    input  logic             in_g,
    output logic             out_valid,
    output logic [CNT_W-1:0] cnt_l,
    output logic [CNT_W-1:0] cnt_e,
    output logic [CNT_W-1:0] cnt_g,
    output logic [CNT_W-1:0] err_cnt,
    output logic             illegal,
    output logic [2:0]       run_kind,
    output logic [RUN_W-1:0] run_len,
    output logic             alarm
);

    logic [2:0]       leg;
    logic             samp, legal, bad, same, run_inc, run_load;
    logic [CNT_W-1:0] cnt_l_nxt, cnt_e_nxt, cnt_g_nxt, err_nxt;
    logic [RUN_W-1:0] run_len_nxt;

    mon_state_t state_q, state_d;
    logic [2:0] run_kind_q, run_kind_d;
    logic       illegal_q, illegal_d;
    logic       alarm_q, alarm_d;
    logic       out_valid_q, out_valid_d;

    // clr drops any same-cycle sample; in_valid gates the code so X on idle inputs is ignored
    assign leg      = {in_l, in_e, in_g};
    assign samp     = in_valid && !clr;
    assign legal    = samp && is_onehot3(leg);
    assign bad      = samp && !is_onehot3(leg);
    assign same     = (leg == run_kind_q);
    assign run_inc  = legal && same;
    assign run_load = legal && !same;

    sat_counter #(.W(CNT_W)) u_cnt_l (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(legal && (leg == LEG_L)),
        .load1(1'b0), .cnt(cnt_l), .cnt_nxt(cnt_l_nxt));
    sat_counter #(.W(CNT_W)) u_cnt_e (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(legal && (leg == LEG_E)),
        .load1(1'b0), .cnt(cnt_e), .cnt_nxt(cnt_e_nxt));
    sat_counter #(.W(CNT_W)) u_cnt_g (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(legal && (leg == LEG_G)),
        .load1(1'b0), .cnt(cnt_g), .cnt_nxt(cnt_g_nxt));
    sat_counter #(.W(CNT_W)) u_err (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(bad),
        .load1(1'b0), .cnt(err_cnt), .cnt_nxt(err_nxt));
    sat_counter #(.W(RUN_W)) u_run (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(run_inc),
        .load1(run_load), .cnt(run_len), .cnt_nxt(run_len_nxt));

    always_comb begin
        state_d     = state_q;
        run_kind_d  = run_kind_q;
        illegal_d   = illegal_q | bad;
        out_valid_d = samp;
        if (clr) begin
            state_d    = IDLE;
            run_kind_d = LEG_NONE;
            illegal_d  = 1'b0;
        end else if (run_load) begin
            // a new run starts at length 1, which already alarms when ALARM_RUN is 1
            run_kind_d = leg;
            state_d    = (ALARM_RUN == 1) ? ALARM : TRACK;
        end else if (run_inc && (run_len_nxt == RUN_W'(ALARM_RUN))) begin
            state_d = ALARM;
        end
        alarm_d = (state_d == ALARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            run_kind_q  <= LEG_NONE;
            illegal_q   <= 1'b0;
            alarm_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_kind_q  <= run_kind_d;
            illegal_q   <= illegal_d;
            alarm_q     <= alarm_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign run_kind  = run_kind_q;
    assign illegal   = illegal_q;
    assign alarm     = alarm_q;
    assign out_valid = out_valid_q;

endmodule
